// File: rtl/intc_nsrc_v2_pkg.sv
// rtl/intc_nsrc_v2_pkg.sv - register offsets, CTRL layout and FSM states for intc_nsrc_v2
package intc_nsrc_v2_pkg;

    localparam logic [31:0] INTC_IE_OFS   = 32'h0000_0000;
    localparam logic [31:0] INTC_IP_OFS   = 32'h0000_0004;
    localparam logic [31:0] INTC_ID_OFS   = 32'h0000_0008;
    localparam logic [31:0] INTC_CTRL_OFS = 32'h0000_000C;
    localparam logic [31:0] INTC_MODE_OFS = 32'h0000_0010;

    typedef enum logic [1:0] {
        INTC_IDLE    = 2'd0,
        INTC_REQ     = 2'd1,
        INTC_SERVICE = 2'd2
    } intc_state_t;

    typedef struct packed {
        logic [30:0] rsvd;
        logic        gie;
    } intc_ctrl_t;

endpackage

// File: rtl/intc_prio_enc.sv
// rtl/intc_prio_enc.sv - fixed-priority encoder, lowest set index wins
module intc_prio_enc #(
    parameter int N_SRC = 16,
    parameter int IDX_W = 5
) (
    input  logic [N_SRC-1:0] i_req,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        // Scan downwards so the lowest set bit is the last assignment.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sfr_module_v1.sv
// rtl/sfr_module_v1.sv - generic read/write SFR storage register
module sfr_module_v1 #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RST_VAL;
        end else if (i_wr_en) begin
            r_q <= i_wdata;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/intc_nsrc_v2.sv
// rtl/intc_nsrc_v2.sv - N-source interrupt controller top; INTC_LEVEL_MODE_EN adds per-source level mode
module intc_nsrc_v2 #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hFFFFF864,
    parameter int                    N_SRC      = 16,
    localparam int                   ID_WIDTH   = $clog2(N_SRC + 1)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [ADDR_WIDTH-1:0] sys_addr,
    input  logic                  sys_wr_en,
    input  logic [DATA_WIDTH-1:0] sys_sw_value,
    input  logic [N_SRC-1:0]      irq_src,
    input  logic                  irq_ack,
    output logic [DATA_WIDTH-1:0] sfr_rd_dout,
    output logic                  irq_req,
    output logic [ID_WIDTH-1:0]   irq_id
);

    import intc_nsrc_v2_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] L_IE_ADDR   = BASE_ADDR + ADDR_WIDTH'(INTC_IE_OFS);
    localparam logic [ADDR_WIDTH-1:0] L_IP_ADDR   = BASE_ADDR + ADDR_WIDTH'(INTC_IP_OFS);
    localparam logic [ADDR_WIDTH-1:0] L_ID_ADDR   = BASE_ADDR + ADDR_WIDTH'(INTC_ID_OFS);
    localparam logic [ADDR_WIDTH-1:0] L_CTRL_ADDR = BASE_ADDR + ADDR_WIDTH'(INTC_CTRL_OFS);
    localparam logic [ADDR_WIDTH-1:0] L_MODE_ADDR = BASE_ADDR + ADDR_WIDTH'(INTC_MODE_OFS);

    logic w_hit_ie, w_hit_ip, w_hit_id, w_hit_ctrl, w_hit_mode;
    logic [N_SRC-1:0] w_ie, w_mode, w_set, w_w1c, w_clr, w_cur_mask;
    logic [N_SRC-1:0] r_ip, r_src_prev;
    logic w_gie, w_win_vld, w_cur_live, w_take, w_eoi, w_unused_wdata;
    logic [ID_WIDTH-1:0] w_win_idx, w_cur_idx, r_irq_id, r_isr_id;
    logic r_irq_req;
    intc_state_t r_state;
    intc_ctrl_t  w_ctrl;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_hit_ie   = (sys_addr == L_IE_ADDR);
    assign w_hit_ip   = (sys_addr == L_IP_ADDR);
    assign w_hit_id   = (sys_addr == L_ID_ADDR);
    assign w_hit_ctrl = (sys_addr == L_CTRL_ADDR);
    assign w_hit_mode = (sys_addr == L_MODE_ADDR);
    assign w_unused_wdata = ^sys_sw_value[DATA_WIDTH-1:N_SRC];

    sfr_module_v1 #(.WIDTH(N_SRC)) u_ie (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_wr_en (sys_wr_en & w_hit_ie),
        .i_wdata (sys_sw_value[N_SRC-1:0]),
        .o_q     (w_ie)
    );

    sfr_module_v1 #(.WIDTH(1)) u_ctrl (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_wr_en (sys_wr_en & w_hit_ctrl),
        .i_wdata (sys_sw_value[0]),
        .o_q     (w_gie)
    );

`ifdef INTC_LEVEL_MODE_EN
    sfr_module_v1 #(.WIDTH(N_SRC)) u_mode (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_wr_en (sys_wr_en & w_hit_mode),
        .i_wdata (sys_sw_value[N_SRC-1:0]),
        .o_q     (w_mode)
    );
`else
    assign w_mode = '0;
`endif

    intc_prio_enc #(.N_SRC(N_SRC), .IDX_W(ID_WIDTH)) u_prio (
        .i_req   (r_ip & w_ie),
        .o_valid (w_win_vld),
        .o_idx   (w_win_idx)
    );

    // Mask of the latched source; irq_id==0 wraps to an index past N_SRC, giving an empty mask.
    assign w_cur_idx  = r_irq_id - ID_WIDTH'(1);
    assign w_cur_mask = N_SRC'(1) << w_cur_idx;
    assign w_cur_live = (|(r_ip & w_ie & w_cur_mask)) & w_gie;
    assign w_take     = (r_state == INTC_REQ) && w_cur_live && irq_ack;
    assign w_eoi      = sys_wr_en && w_hit_id && (r_state == INTC_SERVICE);

    assign w_set = (irq_src & ~r_src_prev) | (irq_src & w_mode);
    assign w_w1c = (sys_wr_en && w_hit_ip) ? sys_sw_value[N_SRC-1:0] : '0;
    assign w_clr = w_w1c | (w_take ? w_cur_mask : '0);

    // A set in the same cycle as any clear of the same bit wins.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_src_prev <= '0;
            r_ip       <= '0;
        end else begin
            r_src_prev <= irq_src;
            r_ip       <= (r_ip & ~w_clr) | w_set;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= INTC_IDLE;
            r_irq_req <= 1'b0;
            r_irq_id  <= '0;
            r_isr_id  <= '0;
        end else begin
            case (r_state)
                INTC_IDLE: begin
                    if (w_gie && w_win_vld) begin
                        r_state   <= INTC_REQ;
                        r_irq_req <= 1'b1;
                        r_irq_id  <= w_win_idx + ID_WIDTH'(1);
                    end
                end
                INTC_REQ: begin
                    if (!w_cur_live) begin
                        r_state   <= INTC_IDLE;
                        r_irq_req <= 1'b0;
                        r_irq_id  <= '0;
                    end else if (irq_ack) begin
                        r_state   <= INTC_SERVICE;
                        r_irq_req <= 1'b0;
                        r_isr_id  <= r_irq_id;
                    end
                end
                INTC_SERVICE: begin
                    if (w_eoi) begin
                        r_state  <= INTC_IDLE;
                        r_isr_id <= '0;
                        r_irq_id <= '0;
                    end
                end
                default: begin
                    r_state <= INTC_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_rdata    = '0;
        w_ctrl     = '0;
        w_ctrl.gie = w_gie;
        if (w_hit_ie)   w_rdata[N_SRC-1:0]    = w_ie;
        if (w_hit_ip)   w_rdata[N_SRC-1:0]    = r_ip;
        if (w_hit_id)   w_rdata[ID_WIDTH-1:0] = r_isr_id;
        if (w_hit_ctrl) w_rdata               = DATA_WIDTH'(w_ctrl);
        if (w_hit_mode) w_rdata[N_SRC-1:0]    = w_mode;
    end

    assign sfr_rd_dout = w_rdata;
    assign irq_req     = r_irq_req;
    assign irq_id      = r_irq_id;

endmodule

// File: tb/tb_intc_nsrc_v2.sv
// tb/tb_intc_nsrc_v2.sv - directed and random checks of intc_nsrc_v2 against a cycle reference model
module tb_intc_nsrc_v2;

    localparam int          N     = 16;
    localparam int          IDW   = $clog2(N + 1);
    localparam logic [31:0] BASE  = 32'hFFFFF864;
    localparam int          S_IDLE = 0, S_REQ = 1, S_SVC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   addr = 32'h0;
    logic          wr_en = 1'b0;
    logic [31:0]   wdata = 32'h0;
    logic [N-1:0]  src = '0;
    logic          ack = 1'b0;
    logic [31:0]   rd_dout;
    logic          irq_req;
    logic [IDW-1:0] irq_id;

    int n_asrt = 0;
    int n_fail = 0;

    logic [N-1:0] m_ip, m_ie, m_prev, m_mode;
    logic         m_gie, m_req;
    int           m_state, m_id, m_isr;

    intc_nsrc_v2 dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .sys_addr     (addr),
        .sys_wr_en    (wr_en),
        .sys_sw_value (wdata),
        .irq_src      (src),
        .irq_ack      (ack),
        .sfr_rd_dout  (rd_dout),
        .irq_req      (irq_req),
        .irq_id       (irq_id)
    );

    always #10 clk = ~clk;

    initial begin
        #4000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic mreset();
        m_ip = '0; m_ie = '0; m_prev = '0; m_mode = '0;
        m_gie = 1'b0; m_req = 1'b0;
        m_state = S_IDLE; m_id = 0; m_isr = 0;
    endtask

    // Advance one clock: predict from the current model and inputs, then compare outputs.
    task automatic tick();
        logic [N-1:0] set, clr;
        logic [31:0]  ofs;
        bit           live, eoi;
        int           w;
        ofs  = addr - BASE;
        set  = src & ~m_prev;
`ifdef INTC_LEVEL_MODE_EN
        set  = set | (src & m_mode);
`endif
        live = (m_id != 0) && m_ip[m_id-1] && m_ie[m_id-1] && m_gie;
        eoi  = wr_en && (ofs == 32'h8) && (m_state == S_SVC);
        clr  = '0;
        if (wr_en && ofs == 32'h4) clr = wdata[N-1:0];
        if (m_state == S_REQ && live && ack) clr[m_id-1] = 1'b1;
        w = lowest(m_ip & m_ie);
        case (m_state)
            S_IDLE: if (m_gie && w >= 0) begin m_state = S_REQ; m_req = 1'b1; m_id = w + 1; end
            S_REQ: begin
                if (!live) begin m_state = S_IDLE; m_req = 1'b0; m_id = 0; end
                else if (ack) begin m_state = S_SVC; m_req = 1'b0; m_isr = m_id; end
            end
            default: if (eoi) begin m_state = S_IDLE; m_isr = 0; m_id = 0; end
        endcase
        m_ip   = (m_ip & ~clr) | set;
        m_prev = src;
        if (wr_en && ofs == 32'h0)  m_ie  = wdata[N-1:0];
        if (wr_en && ofs == 32'hC)  m_gie = wdata[0];
`ifdef INTC_LEVEL_MODE_EN
        if (wr_en && ofs == 32'h10) m_mode = wdata[N-1:0];
`endif
        @(posedge clk);
        #1;
        chk("irq_req", 32'(irq_req), 32'(m_req));
        chk("irq_id", 32'(irq_id), 32'(m_id));
    endtask

    task automatic rd(input string tag, input logic [31:0] ofs, input logic [31:0] exp);
        addr  = BASE + ofs;
        wr_en = 1'b0;
        #1;
        chk(tag, rd_dout, exp);
    endtask

    task automatic wr(input logic [31:0] ofs, input logic [31:0] d);
        addr  = BASE + ofs;
        wdata = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        mreset();
        #3;
        chk("rst_req", 32'(irq_req), 0);
        chk("rst_id", 32'(irq_id), 0);
        rd("rst_ie", 32'h0, 0);
        rd("rst_ip", 32'h4, 0);
        rd("rst_isr", 32'h8, 0);
        rd("rst_ctrl", 32'hC, 0);
        rd("rst_mode", 32'h10, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single source, full handshake
        wr(32'hC, 1);
        wr(32'h0, 1);
        rd("ctrl_rb", 32'hC, 1);
        rd("ie_rb", 32'h0, 1);
        rd("unmapped", 32'h20, 0);
        src = 16'h0001; tick(); src = '0;
        rd("t1_ip", 32'h4, 1);
        chk("t1_req_early", 32'(irq_req), 0);
        tick();
        chk("t1_req", 32'(irq_req), 1);
        chk("t1_id", 32'(irq_id), 1);
        ack = 1'b1; tick(); ack = 1'b0;
        rd("t1_ip_ack", 32'h4, 0);
        rd("t1_isr", 32'h8, 1);
        wr(32'h8, 0);
        rd("t1_isr_eoi", 32'h8, 0);
        tick();
        chk("t1_idle", 32'(irq_req), 0);

        // Simultaneous sources 3 and 5
        wr(32'h0, 32'hFFFF);
        src = 16'h0028; tick(); src = '0;
        tick();
        chk("t2_id4", 32'(irq_id), 4);
        ack = 1'b1; tick(); ack = 1'b0;
        wr(32'h8, 0);
        tick();
        chk("t2_req6", 32'(irq_req), 1);
        chk("t2_id6", 32'(irq_id), 6);
        ack = 1'b1; tick(); ack = 1'b0;
        wr(32'h8, 0);

        // Withdraw by W1C while requesting
        src = 16'h0008; tick(); src = '0;
        tick();
        chk("t3_id4", 32'(irq_id), 4);
        wr(32'h4, 32'h8);
        tick();
        chk("t3_wd_req", 32'(irq_req), 0);
        chk("t3_wd_id", 32'(irq_id), 0);
        repeat (3) tick();
        chk("t3_quiet", 32'(irq_req), 0);
        rd("t3_ip", 32'h4, 0);

        // No nesting during service
        src = 16'h0001; tick(); src = '0;
        tick();
        ack = 1'b1; tick(); ack = 1'b0;
        src = 16'h0001; tick(); src = '0;
        rd("t4_ip", 32'h4, 1);
        chk("t4_noreq", 32'(irq_req), 0);
        tick();
        chk("t4_noreq2", 32'(irq_req), 0);
        wr(32'h8, 0);
        chk("t4_eoi_edge", 32'(irq_req), 0);
        tick();
        chk("t4_req", 32'(irq_req), 1);
        chk("t4_id", 32'(irq_id), 1);
        ack = 1'b1; tick(); ack = 1'b0;
        wr(32'h8, 0);

        // Set beats W1C on the same bit
        wr(32'hC, 0);
        src = 16'h0004; tick(); src = '0;
        tick();
        rd("t5_ip", 32'h4, 4);
        src = 16'h0004; wr(32'h4, 32'h4); src = '0;
        rd("t5_setwins", 32'h4, 4);
        wr(32'h4, 32'h4);
        rd("t5_cleared", 32'h4, 0);

        // Asynchronous reset while requesting
        wr(32'hC, 1);
        src = 16'h0001; tick(); src = '0;
        tick();
        chk("t6_req", 32'(irq_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_req", 32'(irq_req), 0);
        chk("t6_rst_id", 32'(irq_id), 0);
        rd("t6_rst_ip", 32'h4, 0);
        rd("t6_rst_ie", 32'h0, 0);
        mreset();
        rst_n = 1'b1;

`ifdef INTC_LEVEL_MODE_EN
        wr(32'hC, 1);
        wr(32'h0, 32'h80);
        wr(32'h10, 32'h80);
        rd("t7_mode", 32'h10, 32'h80);
        src = 16'h0080; tick();
        tick();
        chk("t7_id", 32'(irq_id), 8);
        wr(32'h4, 32'h80);
        rd("t7_w1c_nop", 32'h4, 32'h80);
        ack = 1'b1; tick(); ack = 1'b0;
        rd("t7_ip_ack", 32'h4, 32'h80);
        src = '0;
        wr(32'h4, 32'h80);
        rd("t7_ip_clr", 32'h4, 0);
        wr(32'h8, 0);
`else
        wr(32'h10, 32'hFFFF);
        rd("t7_mode_ro", 32'h10, 0);
`endif

        // Random traffic against the model
        wr(32'hC, 1);
        wr(32'h0, 32'($urandom_range(0, 16'hFFFF)));
        for (int k = 0; k < 600; k++) begin
            int op;
            src   = ($urandom_range(0, 3) == 0) ? N'($urandom & $urandom) : '0;
            ack   = ($urandom_range(0, 2) == 0);
            op    = $urandom_range(0, 9);
            wr_en = 1'b0;
            addr  = BASE + 32'h20;
            case (op)
                0: begin addr = BASE;          wdata = $urandom; wr_en = 1'b1; end
                1: begin addr = BASE + 32'h4;  wdata = $urandom; wr_en = 1'b1; end
                2, 3: begin addr = BASE + 32'h8; wdata = $urandom; wr_en = 1'b1; end
                4: begin addr = BASE + 32'hC;  wdata = 32'($urandom_range(0, 4) != 0); wr_en = 1'b1; end
                default: ;
            endcase
            tick();
            wr_en = 1'b0;
            ack   = 1'b0;
            rd("rnd_ip", 32'h4, 32'(m_ip));
            rd("rnd_isr", 32'h8, 32'(m_isr));
            rd("rnd_ie", 32'h0, 32'(m_ie));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/intc_nsrc_v2.md
Name: intc_nsrc_v2

Overview:
Parametrised interrupt controller for the pipeline MCU. It aggregates N_SRC peripheral event lines (TMR match/ovf, PWM pr/dc/ph/of, ...) into per-source pending, enable and global-enable state, all SFR-mapped. It drives a registered request/ID handshake towards the CPU and is sequenced by an IDLE/REQ/SERVICE state machine. It sits beside the peripherals on the SFR bus, and its read data is ORed into the system SFR read bus.

Parameters:
DATA_WIDTH, 32, SFR data width
ADDR_WIDTH, 32, system address width
BASE_ADDR, 32'hFFFFF864, SFR block base address (word aligned)
N_SRC, 16, number of interrupt sources, legal range 1..31
ID_WIDTH (localparam), $clog2(N_SRC+1), interrupt ID width; ID 0 means none

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
sys_addr  in  ADDR_WIDTH  CPU request address
sys_wr_en  in  1  SFR write strobe (cpu_wr_en & en_mem_sfr)
sys_sw_value  in  DATA_WIDTH  CPU write data
irq_src  in  N_SRC  peripheral event lines, sys_clk domain
irq_ack  in  1  CPU accepts the current request (1-cycle pulse)
sfr_rd_dout  out  DATA_WIDTH  read data; all-zero when no register of this block is addressed
irq_req  out  1  registered interrupt request to the CPU
irq_id  out  ID_WIDTH  registered ID of the requested source (index+1)

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_rst_n is asynchronous and active-low. On reset, all registers, irq_req, irq_id and the FSM (IDLE) clear to 0.
- SFR map (offsets from BASE_ADDR):
  - +0x00 IE: RW, bits [N_SRC-1:0].
  - +0x04 IP: R; write-1-to-clear.
  - +0x08 ISR_ID: R returns the in-service ID (0 if none); any write = EOI.
  - +0x0C CTRL: bit0 GIE, RW.
  - +0x10 MODE: see Optional Feature.
  - Unimplemented bits read 0. Reads are combinational with no side effects.
- Edge capture: src_prev[i] is registered and resets to 0. A rising edge (irq_src & ~src_prev) sets IP[i] at the next edge. A source already high at reset release therefore registers one edge.
- Set priority: an IP set in the same cycle as a W1C or an ack-clear of the same bit wins (the bit stays 1).
- Priority: fixed, lowest index highest. The winner is taken from IP & IE.
- FSM:
  - IDLE: if GIE & |(IP&IE), go to REQ. Latch irq_id = winner+1 and set irq_req=1.
  - REQ: irq_id is frozen. irq_ack=1 goes to SERVICE: clear IP[irq_id-1], load ISR_ID=irq_id, set irq_req=0. If the latched source loses IP or IE, or GIE drops, before ack, withdraw: irq_req=0, irq_id=0, go to IDLE (ack in that same cycle is ignored).
  - SERVICE: no new request (no nesting), and pending bits keep accumulating. An EOI write clears ISR_ID and irq_id and returns to IDLE. A new request can issue the cycle after that.
- irq_ack outside REQ is ignored. An EOI write outside SERVICE is ignored.
- Latency: irq_src rises before edge n, IP is set at edge n, and irq_req=1 after edge n+1.
- Reset mid-operation: everything returns to reset values immediately, and a request in flight is dropped.

Optional Feature:
- Macro: INTC_LEVEL_MODE_EN.
- When defined:
  - MODE at +0x10 is RW, bits [N_SRC-1:0]; 1 = level-sensitive.
  - A level source sets IP every cycle while irq_src[i]=1, so W1C and ack-clear are ineffective while the line is high.
- When undefined: MODE reads 0, writes are ignored, and all sources are edge-triggered.

Decomposition:
- Add to pkg_sfrs_definition:
  - intc_ctrl_t packed struct (gie + reserved bits).
  - Localparam offsets INTC_IE_OFS, INTC_IP_OFS, INTC_ID_OFS, INTC_CTRL_OFS, INTC_MODE_OFS.
  - intc_state_t enum {INTC_IDLE, INTC_REQ, INTC_SERVICE}.
- IE and CTRL are instances of sfr_module_v1.
- Sub-module intc_prio_enc: parametrised N_SRC-input fixed-priority encoder that outputs a valid flag and an index.

Test Plan:
- Reset, then GIE=1, IE=0x0001, pulse irq_src[0] for 1 cycle -> IP=0x1, irq_req=1 two cycles after the edge, irq_id=1; irq_ack -> IP=0, ISR_ID reads 1; EOI write -> ISR_ID=0, FSM IDLE.
- Sources 3 and 5 rise in the same cycle, IE=0xFFFF -> irq_id=4 first; after ack+EOI -> irq_id=6.
- In REQ for ID 4, W1C IP with 0x0008 -> irq_req falls next cycle, irq_id=0, and no further request.
- In SERVICE for ID 1, source 0 rises again -> IP[0]=1 while irq_req stays 0; EOI -> irq_req=1 with irq_id=1.
- W1C of IP[2] in the same cycle as a new rising edge on src 2 -> IP[2] remains 1. Assert sys_rst_n=0 while in REQ -> irq_req=0 and IP=0 asynchronously.
- INTC_LEVEL_MODE_EN, MODE[7]=1, hold irq_src[7] high -> W1C has no effect and, after ack, IP[7] re-sets next cycle; undefined build -> MODE reads 0x0.
